multi_led_blinker: RTL and testbench

Parametrised multi-channel LED driver. It generalises the single fixed-interval blinker to NUM_CH independent channels, each with its own mode: off, on, blink, or pattern playback. A single shared millisecond prescaler feeds all channels. Each channel loads its configuration through a write strobe and emits a one-cycle step pulse for status/interrupt logic.

---
 rtl/multi_led_blinker.sv | 150 +++++++++++++++
 tb/tb_multi_led_blinker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multi_led_blinker.sv
// -----------------------------------------------------------------------------
// multi_led_blinker
//
// Multi-channel LED driver. One shared prescaler produces a 1 ms tick. Each
// channel runs independently in one of four modes: off, on, blink (toggle
// every `interval` ms) or pattern playback (advance one bit every `interval`
// ms, bit 0 first, wrapping after the last bit).
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset (synchronous release upstream)
//   cfg_we          per-channel config load strobe (one bit per channel)
//   cfg_mode        mode to load: 00 off, 01 on, 10 blink, 11 pattern
//   cfg_interval_ms interval to load, in ms (0 halts blink/pattern)
//   cfg_pattern     pattern to load, bit 0 plays first
//   led             registered LED outputs, one per channel
//   step            one-cycle pulse per channel on each toggle/pattern advance
//   ms_tick         one-cycle pulse once per ms from the shared prescaler
// -----------------------------------------------------------------------------
module multi_led_blinker #(
  parameter int NUM_CH     = 4,
  parameter int CLK_PER_MS = 100000,
  parameter int INTERVAL_W = 16,
  parameter int PATTERN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     cfg_we,
  input  logic [1:0]            cfg_mode,
  input  logic [INTERVAL_W-1:0] cfg_interval_ms,
  input  logic [PATTERN_W-1:0]  cfg_pattern,
  output logic [NUM_CH-1:0]     led,
  output logic [NUM_CH-1:0]     step,
  output logic                  ms_tick
);

  localparam int PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int IDX_W   = $clog2(PATTERN_W);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(PATTERN_W - 1);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_PATTERN = 2'b11;

  // Shared prescaler
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ms_tick_q, ms_tick_d;

  // Per-channel state
  logic [1:0]            mode_q     [NUM_CH];
  logic [1:0]            mode_d     [NUM_CH];
  logic [INTERVAL_W-1:0] interval_q [NUM_CH];
  logic [INTERVAL_W-1:0] interval_d [NUM_CH];
  logic [PATTERN_W-1:0]  pattern_q  [NUM_CH];
  logic [PATTERN_W-1:0]  pattern_d  [NUM_CH];
  logic [INTERVAL_W-1:0] ms_cnt_q   [NUM_CH];
  logic [INTERVAL_W-1:0] ms_cnt_d   [NUM_CH];
  logic [IDX_W-1:0]      idx_q      [NUM_CH];
  logic [IDX_W-1:0]      idx_d      [NUM_CH];
  logic [NUM_CH-1:0]     led_q, led_d;
  logic [NUM_CH-1:0]     step_q, step_d;

  // ms_tick is registered, so it is high in the cycle the counter shows 0
  // after wrapping from CLK_PER_MS-1.
  always_comb begin
    ms_tick_d = (presc_q == PRESC_MAX);
    presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    mode_d     = mode_q;
    interval_d = interval_q;
    pattern_d  = pattern_q;
    ms_cnt_d   = ms_cnt_q;
    idx_d      = idx_q;
    led_d      = led_q;
    step_d     = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we[i]) begin
        // A write takes priority over any event landing in the same cycle.
        mode_d[i]     = cfg_mode;
        interval_d[i] = cfg_interval_ms;
        pattern_d[i]  = cfg_pattern;
        ms_cnt_d[i]   = '0;
        idx_d[i]      = '0;
        case (cfg_mode)
          MODE_ON:      led_d[i] = 1'b1;
          MODE_PATTERN: led_d[i] = cfg_pattern[0];
          default:      led_d[i] = 1'b0;
        endcase
      end else if (mode_q[i][1] && (interval_q[i] != '0)) begin
        // Blink or pattern with a non-zero interval: count ms ticks.
        if (ms_tick_q) begin
          if (ms_cnt_q[i] == interval_q[i] - 1'b1) begin
            ms_cnt_d[i] = '0;
            step_d[i]   = 1'b1;
            if (mode_q[i] == MODE_BLINK) begin
              led_d[i] = ~led_q[i];
            end else begin
              idx_d[i] = (idx_q[i] == IDX_MAX) ? '0 : idx_q[i] + 1'b1;
              led_d[i] = pattern_q[i][idx_d[i]];
            end
          end else begin
            ms_cnt_d[i] = ms_cnt_q[i] + 1'b1;
          end
        end
      end else begin
        // Off, on, or halted (interval 0): hold led, keep the counter cleared.
        ms_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      ms_tick_q <= 1'b0;
      led_q     <= '0;
      step_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= MODE_OFF;
        interval_q[i] <= '0;
        pattern_q[i]  <= '0;
        ms_cnt_q[i]   <= '0;
        idx_q[i]      <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      ms_tick_q <= ms_tick_d;
      led_q     <= led_d;
      step_q    <= step_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]     <= mode_d[i];
        interval_q[i] <= interval_d[i];
        pattern_q[i]  <= pattern_d[i];
        ms_cnt_q[i]   <= ms_cnt_d[i];
        idx_q[i]      <= idx_d[i];
      end
    end
  end

  assign led     = led_q;
  assign step    = step_q;
  assign ms_tick = ms_tick_q;

endmodule

// File: tb/tb_multi_led_blinker.sv
module tb_multi_led_blinker;

  localparam int NUM_CH     = 4;
  localparam int CLK_PER_MS = 4;
  localparam int INTERVAL_W = 16;
  localparam int PATTERN_W  = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_CH-1:0]     cfg_we;
  logic [1:0]            cfg_mode;
  logic [INTERVAL_W-1:0] cfg_interval_ms;
  logic [PATTERN_W-1:0]  cfg_pattern;
  logic [NUM_CH-1:0]     led;
  logic [NUM_CH-1:0]     step;
  logic                  ms_tick;

  int tests_run;
  int tests_failed;
  int cyc;

  multi_led_blinker #(
    .NUM_CH    (NUM_CH),
    .CLK_PER_MS(CLK_PER_MS),
    .INTERVAL_W(INTERVAL_W),
    .PATTERN_W (PATTERN_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_mode       (cfg_mode),
    .cfg_interval_ms(cfg_interval_ms),
    .cfg_pattern    (cfg_pattern),
    .led            (led),
    .step           (step),
    .ms_tick        (ms_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a config for exactly one edge.
  task automatic do_write(input logic [NUM_CH-1:0] we, input logic [1:0] mode,
                          input logic [INTERVAL_W-1:0] iv, input logic [PATTERN_W-1:0] pat);
    cfg_we          = we;
    cfg_mode        = mode;
    cfg_interval_ms = iv;
    cfg_pattern     = pat;
    step_clk();
    cfg_we = '0;
  endtask

  logic [7:0] pat1;

  initial begin
    int d;
    int k;
    int ticks;
    tests_run       = 0;
    tests_failed    = 0;
    cyc             = 0;
    ticks           = 0;
    pat1            = 8'b1011_0010;
    rst_n           = 1'b0;
    cfg_we          = '0;
    cfg_mode        = 2'b00;
    cfg_interval_ms = '0;
    cfg_pattern     = '0;

    // Held in reset
    repeat (3) step_clk();
    check("rst_led", led, 0);
    check("rst_step", step, 0);
    check("rst_tick", ms_tick, 0);

    // Release between edges; the next edge is edge 1
    rst_n = 1'b1;
    cyc   = 0;

    // Idle: no writes, tick every 4 clk at edges 4, 8, ...
    for (int e = 1; e <= 100; e++) begin
      step_clk();
      check("idle_led", led, 0);
      check("idle_step", step, 0);
      check("idle_tick", ms_tick, (e % 4 == 0) ? 1 : 0);
      if (ms_tick) ticks++;
    end
    check("idle_tick_count", ticks, 25);

    // ch0 blink interval 3, loaded at edge 101 (tick at that edge is overridden)
    do_write(4'b0001, 2'b10, 16'd3, 8'h00);
    check("blink_load_led", led, 4'b0000);
    check("blink_load_step", step, 4'b0000);
    for (int e = 102; e <= 150; e++) begin
      step_clk();
      d = e - 101;
      check("blink_led0", led[0], (d / 12) % 2);
      check("blink_step0", step[0], (d % 12 == 0) ? 1 : 0);
      check("blink_others", led[3:1], 0);
    end

    // ch1 pattern 1011_0010 interval 1, loaded at edge 151; ticks at 153, 157, ...
    do_write(4'b0010, 2'b11, 16'd1, pat1);
    check("pat_load_led1", led[1], 0);
    check("pat_load_step1", step[1], 0);
    for (int e = 152; e <= 190; e++) begin
      step_clk();
      d = e - 101;
      k = (e >= 153) ? ((e - 153) / 4 + 1) : 0;
      check("pat_led1", led[1], pat1[k % 8]);
      check("pat_step1", step[1], (e >= 153 && (e - 153) % 4 == 0) ? 1 : 0);
      check("pat_ch0_led", led[0], (d / 12) % 2);
      check("pat_ch0_step", step[0], (d % 12 == 0) ? 1 : 0);
    end

    // ch2 on then off; ch3 blink with interval 0
    do_write(4'b0100, 2'b01, 16'd5, 8'h00);
    check("on_led2", led[2], 1);
    check("on_step2", step[2], 0);
    do_write(4'b0100, 2'b00, 16'd5, 8'h00);
    check("off_led2", led[2], 0);
    check("off_step2", step[2], 0);
    do_write(4'b1000, 2'b10, 16'd0, 8'h00);
    check("halt_led3", led[3], 0);
    for (int e = 194; e <= 220; e++) begin
      step_clk();
      check("quiet_led32", led[3:2], 0);
      check("quiet_step32", step[3:2], 0);
    end

    // ch0 event pending at edge 221; rewrite ch0 blink interval 2 in that cycle
    check("pre_rewrite_led0", led[0], 1);
    do_write(4'b0001, 2'b10, 16'd2, 8'h00);
    check("rewrite_led0", led[0], 0);
    check("rewrite_step0", step[0], 0);
    for (int e = 222; e <= 229; e++) begin
      step_clk();
      check("rewrite_run_led0", led[0], (e == 229) ? 1 : 0);
      check("rewrite_run_step0", step[0], (e == 229) ? 1 : 0);
    end

    // Async reset while led0=1 and step0 high
    rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 0);
    check("async_rst_step", step, 0);
    check("async_rst_tick", ms_tick, 0);
    repeat (2) step_clk();
    rst_n = 1'b1;
    cyc   = 0;
    for (int e = 1; e <= 20; e++) begin
      step_clk();
      check("post_rst_led", led, 0);
      check("post_rst_step", step, 0);
      check("post_rst_tick", ms_tick, (e % 4 == 0) ? 1 : 0);
    end

    // Rewrite after reset, and a multi-channel load
    do_write(4'b0001, 2'b01, 16'd0, 8'h00);
    check("post_rst_on_led", led, 4'b0001);
    do_write(4'b0110, 2'b11, 16'd5, 8'h01);
    check("multi_load_led", led, 4'b0111);
    check("multi_load_step", step, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
